// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: minuteCore fetch/data request ports plus the shared external memory bus.
interface mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic [ADDR_W-1:0] imem_rd_addr;
  logic              imem_rd_enable;
  logic [DATA_W-1:0] imem_rd_data;
  logic              imem_rd_ready;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_r_enable;
  logic              dmem_w_enable;
  logic [1:0]        dmem_w_size;
  logic [DATA_W-1:0] dmem_w_data;
  logic [DATA_W-1:0] dmem_r_data;
  logic              dmem_ready;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [1:0]        bus_w_size;
  logic [DATA_W-1:0] bus_w_data;
  logic [DATA_W-1:0] bus_r_data;
  logic              bus_ack;
  modport slave (
    input  imem_rd_addr, imem_rd_enable, dmem_addr, dmem_r_enable, dmem_w_enable,
           dmem_w_size, dmem_w_data, bus_r_data, bus_ack,
    output imem_rd_data, imem_rd_ready, dmem_r_data, dmem_ready,
           bus_req, bus_we, bus_addr, bus_w_size, bus_w_data
  );
  modport master (
    output imem_rd_addr, imem_rd_enable, dmem_addr, dmem_r_enable, dmem_w_enable,
           dmem_w_size, dmem_w_data, bus_r_data, bus_ack,
    input  imem_rd_data, imem_rd_ready, dmem_r_data, dmem_ready,
           bus_req, bus_we, bus_addr, bus_w_size, bus_w_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serves fetch and data ports one transaction at a time over a single bus.
// MEM_ARB_RR_EN selects round-robin arbitration; otherwise the data port always wins.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.slave mif
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state, next;
  logic i_elig, d_elig, d_wins, grant_i, grant_d, done;
  // A requester whose ready is high is still holding the request just completed.
  assign i_elig = mif.imem_rd_enable && !mif.imem_rd_ready;
  assign d_elig = (mif.dmem_r_enable || mif.dmem_w_enable) && !mif.dmem_ready;
`ifdef MEM_ARB_RR_EN
  logic last_d;
  assign d_wins = !i_elig || !last_d;
  always_ff @(posedge clk) last_d <= reset ? 1'b0 : grant_d ? 1'b1 : grant_i ? 1'b0 : last_d;
`else
  assign d_wins = 1'b1;
`endif
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_comb begin
    grant_d = state == IDLE && d_elig && d_wins;
    grant_i = state == IDLE && i_elig && !grant_d;
    done = state != IDLE && mif.bus_ack;
    next = grant_d ? BUSY_D : grant_i ? BUSY_I : done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mif.bus_req <= 1'b0;
      mif.bus_we <= 1'b0;
      mif.bus_addr <= {ADDR_W{1'b0}};
      mif.bus_w_size <= 2'd0;
      mif.bus_w_data <= {DATA_W{1'b0}};
      mif.imem_rd_data <= {DATA_W{1'b0}};
      mif.imem_rd_ready <= 1'b0;
      mif.dmem_r_data <= {DATA_W{1'b0}};
      mif.dmem_ready <= 1'b0;
    end else begin
      mif.imem_rd_ready <= done && state == BUSY_I;
      mif.dmem_ready <= done && state == BUSY_D;
      if (grant_d || grant_i) begin
        mif.bus_req <= 1'b1;
        mif.bus_we <= grant_d && mif.dmem_w_enable;
        mif.bus_addr <= grant_d ? mif.dmem_addr : mif.imem_rd_addr;
        mif.bus_w_size <= grant_d ? mif.dmem_w_size : 2'd0;
        mif.bus_w_data <= grant_d ? mif.dmem_w_data : {DATA_W{1'b0}};
      end else if (done) begin
        mif.bus_req <= 1'b0;
      end
      if (done && state == BUSY_I) mif.imem_rd_data <= mif.bus_r_data;
      if (done && state == BUSY_D && !mif.bus_we) mif.dmem_r_data <= mif.bus_r_data;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random traffic against a transaction-level model with a scoreboard.
module tb_mem_arbiter;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {int cyc; logic we; logic [31:0] addr; logic [1:0] size; logic [31:0] wdata;} bus_t;
  typedef struct {int cyc; logic [31:0] data;} rdy_t;
  logic clk = 1'b0;
  logic reset;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bus_t bq[$];
  rdy_t iq[$];
  rdy_t dq[$];
  bus_t eb;
  rdy_t er;
  bit i_act, d_act, d_we, d_re, rnd, hold_i, force_ack, rst_req;
  logic [31:0] i_addr, d_addr, d_wdata, rd_fix;
  logic [1:0] d_size;
  int ack_delay, resp_cnt;
  int ms;
  bit mi_rdy, md_rdy, m_last_d, m_we;
  logic [31:0] mi_data, md_data;
  logic prev_req = 1'b0;
  logic h_we;
  logic [31:0] h_addr, h_wdata;
  logic [1:0] h_size;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .reset(reset), .mif(mif));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT starts a transaction or pulses ready.
  always @(negedge clk) begin
    if (mif.bus_req && !prev_req) begin
      chk("bus_expected", bq.size() != 0, 1);
      if (bq.size() != 0) begin
        eb = bq.pop_front();
        chk("bus_cycle", cyc, eb.cyc);
        chk("bus_we", mif.bus_we, eb.we);
        chk("bus_addr", mif.bus_addr, eb.addr);
        chk("bus_w_size", mif.bus_w_size, eb.size);
        chk("bus_w_data", mif.bus_w_data, eb.wdata);
      end
    end else if (mif.bus_req) begin
      chk("hold_we", mif.bus_we, h_we);
      chk("hold_addr", mif.bus_addr, h_addr);
      chk("hold_size", mif.bus_w_size, h_size);
      chk("hold_wdata", mif.bus_w_data, h_wdata);
    end
    if (mif.imem_rd_ready) begin
      chk("i_ready_expected", iq.size() != 0, 1);
      if (iq.size() != 0) begin
        er = iq.pop_front();
        chk("i_ready_cycle", cyc, er.cyc);
        chk("imem_rd_data", mif.imem_rd_data, er.data);
      end
    end
    if (mif.dmem_ready) begin
      chk("d_ready_expected", dq.size() != 0, 1);
      if (dq.size() != 0) begin
        er = dq.pop_front();
        chk("d_ready_cycle", cyc, er.cyc);
        chk("dmem_r_data", mif.dmem_r_data, er.data);
      end
    end
    prev_req <= mif.bus_req;
    h_we <= mif.bus_we;
    h_addr <= mif.bus_addr;
    h_size <= mif.bus_w_size;
    h_wdata <= mif.bus_w_data;
  end

  // One cycle: requesters and bus responder drive inputs, then the model predicts the next edge.
  task automatic step();
    bit ie, de, ni, nd;
    @(negedge clk);
    if (i_act && mif.imem_rd_ready && !hold_i) i_act = 0;
    if (d_act && mif.dmem_ready) d_act = 0;
    if (rnd) begin
      if (!i_act && !mif.imem_rd_ready && $urandom_range(3) == 0) begin
        i_act = 1;
        i_addr = $urandom;
      end else if (i_act && $urandom_range(40) == 0) i_act = 0;
      if (!d_act && !mif.dmem_ready && $urandom_range(3) == 0) begin
        d_act = 1;
        d_we = 1'($urandom_range(1));
        d_re = !d_we || 1'($urandom_range(1));
        d_addr = $urandom;
        d_size = 2'($urandom_range(3));
        d_wdata = $urandom;
      end else if (d_act && $urandom_range(40) == 0) d_act = 0;
    end
    mif.imem_rd_enable = i_act;
    mif.imem_rd_addr = i_addr;
    mif.dmem_r_enable = d_act && d_re;
    mif.dmem_w_enable = d_act && d_we;
    mif.dmem_addr = d_addr;
    mif.dmem_w_size = d_size;
    mif.dmem_w_data = d_wdata;
    resp_cnt = mif.bus_req ? resp_cnt + 1 : 0;
    if (rnd && resp_cnt == 1) ack_delay = $urandom_range(4);
    mif.bus_ack = force_ack || (mif.bus_req ? resp_cnt > ack_delay : rnd && $urandom_range(7) == 0);
    mif.bus_r_data = rnd ? $urandom : rd_fix;
    reset = rst_req;
    ni = 0;
    nd = 0;
    if (reset) begin
      ms = 0;
      m_last_d = 0;
      mi_data = '0;
      md_data = '0;
    end else begin
      ie = mif.imem_rd_enable && !mi_rdy;
      de = (mif.dmem_r_enable || mif.dmem_w_enable) && !md_rdy;
      if (ms == 0 && de && !(ie && RR && m_last_d)) begin
        m_we = mif.dmem_w_enable;
        bq.push_back('{cyc + 1, m_we, mif.dmem_addr, mif.dmem_w_size, mif.dmem_w_data});
        ms = 2;
        m_last_d = 1;
      end else if (ms == 0 && ie) begin
        bq.push_back('{cyc + 1, 1'b0, mif.imem_rd_addr, 2'd0, 32'd0});
        ms = 1;
        m_last_d = 0;
      end else if (ms != 0 && mif.bus_ack) begin
        if (ms == 1) begin
          mi_data = mif.bus_r_data;
          iq.push_back('{cyc + 1, mi_data});
          ni = 1;
        end else begin
          if (!m_we) md_data = mif.bus_r_data;
          dq.push_back('{cyc + 1, md_data});
          nd = 1;
        end
        ms = 0;
      end
    end
    mi_rdy = ni;
    md_rdy = nd;
  endtask

  task automatic wait_i(string n);
    for (int k = 0; k < 200 && i_act; k++) step();
    chk(n, i_act, 0);
  endtask

  task automatic wait_d(string n);
    for (int k = 0; k < 200 && d_act; k++) step();
    chk(n, d_act, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    rst_req = 1;
    {i_act, d_act, d_we, d_re, rnd, hold_i, force_ack} = '0;
    {i_addr, d_addr, d_wdata, rd_fix} = '0;
    d_size = 2'd0;
    ack_delay = 0;
    resp_cnt = 0;
    {mif.imem_rd_enable, mif.dmem_r_enable, mif.dmem_w_enable, mif.bus_ack} = '0;
    {mif.imem_rd_addr, mif.dmem_addr, mif.dmem_w_data, mif.bus_r_data} = '0;
    mif.dmem_w_size = 2'd0;
    repeat (3) step();
    chk("rst_bus_req", mif.bus_req, 0);
    chk("rst_bus_we", mif.bus_we, 0);
    chk("rst_bus_addr", mif.bus_addr, 0);
    chk("rst_bus_w_size", mif.bus_w_size, 0);
    chk("rst_bus_w_data", mif.bus_w_data, 0);
    chk("rst_imem_rd_data", mif.imem_rd_data, 0);
    chk("rst_imem_rd_ready", mif.imem_rd_ready, 0);
    chk("rst_dmem_r_data", mif.dmem_r_data, 0);
    chk("rst_dmem_ready", mif.dmem_ready, 0);
    rst_req = 0;
    step();
    ack_delay = 2;
    rd_fix = 32'h00A00093;
    i_addr = 32'h100;
    i_act = 1;
    wait_i("fetch_done");
    chk("fetch_data", mif.imem_rd_data, 32'h00A00093);
    step();
    chk("fetch_pulse_end", mif.imem_rd_ready, 0);
    d_addr = 32'h2000;
    d_wdata = 32'hDEADBEEF;
    d_size = 2'd2;
    d_we = 1;
    d_re = 0;
    d_act = 1;
    wait_d("store_done");
    chk("store_r_data_kept", mif.dmem_r_data, 0);
    chk("store_we", mif.bus_we, 1);
    chk("store_size", mif.bus_w_size, 2);
    step();
    chk("store_pulse_end", mif.dmem_ready, 0);
    d_addr = 32'h2004;
    i_addr = 32'h104;
    d_act = 1;
    i_act = 1;
    for (int k = 0; k < 20 && !mif.bus_req; k++) step();
    chk("contention_winner_we", mif.bus_we, RR ? 0 : 1);
    for (int k = 0; k < 200 && (i_act || d_act); k++) step();
    chk("contention_drained", i_act || d_act, 0);
    ack_delay = 0;
    hold_i = 1;
    i_addr = 32'h200;
    i_act = 1;
    for (int k = 0; k < 50 && !mif.imem_rd_ready; k++) step();
    chk("b2b_first_ready", mif.imem_rd_ready, 1);
    step();
    chk("b2b_no_dup_grant", mif.bus_req, 0);
    step();
    chk("b2b_refetch", mif.bus_req, 1);
    hold_i = 0;
    wait_i("b2b_done");
    ack_delay = 10;
    d_we = 0;
    d_re = 1;
    d_addr = 32'h3000;
    d_act = 1;
    n = 0;
    for (int k = 0; k < 100 && d_act; k++) begin
      step();
      if (mif.bus_req) n++;
    end
    chk("ackhold_req_cycles", n, 11);
    ack_delay = 50;
    d_addr = 32'h3004;
    d_act = 1;
    for (int k = 0; k < 20 && !mif.bus_req; k++) step();
    chk("rstmid_granted", mif.bus_req, 1);
    step();
    rst_req = 1;
    d_act = 0;
    force_ack = 1;
    step();
    rst_req = 0;
    step();
    chk("rstmid_req_drop", mif.bus_req, 0);
    chk("rstmid_no_ready", mif.dmem_ready, 0);
    repeat (3) begin
      step();
      chk("rstmid_ack_ignored", mif.dmem_ready, 0);
      chk("rstmid_idle", mif.bus_req, 0);
    end
    force_ack = 0;
    rnd = 1;
    repeat (3000) step();
    rnd = 0;
    ack_delay = 2;
    for (int k = 0; k < 300 && (i_act || d_act || mif.bus_req); k++) step();
    repeat (3) step();
    chk("leftover_bus", bq.size(), 0);
    chk("leftover_i", iq.size(), 0);
    chk("leftover_d", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
